alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: N, default 4, data width of accumulator, operand and ALU data ports.
REQ-002 Ports, clock and reset first; reset is asynchronous, active-low:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  operation request.
- op_code  input  4  operation code; same 4-bit encoding as the ALU select field.
- op_operand  input  N  second operand.
- op_ready  output  1  request accepted when op_valid and op_ready are both high.
- alu_a  output  N  ALU operand a.
- alu_b  output  N  ALU operand b.
- alu_select  output  4  ALU operation select.
- alu_result  input  N  ALU result.
- alu_z, alu_s, alu_v, alu_c  input  1 each  ALU zero, sign, overflow and carry flags.
- acc  output  N  accumulator.
- flag_z, flag_s, flag_v, flag_c  output  1 each  registered flags.
- done  output  1  one-cycle completion pulse.
- op_illegal  output  1  present only under ALU_CTRL_ILLEGAL_EN (REQ-016).

Function
REQ-003 FSM states IDLE, EXEC, DONE; transitions IDLE->EXEC on accept, EXEC->DONE always, DONE->IDLE always.
REQ-004 op_ready is high only in IDLE; op_valid in EXEC or DONE is ignored and produces no side effect.
REQ-005 On accept: latch op_code and op_operand; register alu_a, alu_b and alu_select so they are stable for the whole EXEC cycle.
REQ-006 Drive rules: alu_a=acc, alu_b=operand, alu_select=op_code, except as stated in REQ-007 and REQ-008.
REQ-007 op_code 0111 is LOAD: alu_a=operand, alu_select=0000, result loaded into acc.
REQ-008 op_code 0011 is ADC: alu_select=0011 if flag_c=1, else 0010.
REQ-009 At the end of EXEC, for defined codes, capture acc<=alu_result and all four flags from the ALU inputs.
REQ-010 Defined codes: 0000-0111, 1000, 1010, 1100, 1110.
REQ-011 Undefined codes (1001, 1011, 1101, 1111) are NOP: acc and flags are unchanged, done still pulses.
REQ-012 done is high for exactly the DONE cycle.
REQ-013 acc and flags show the new values in the DONE cycle.
REQ-014 Latency is 2 cycles from accept to done; maximum throughput is one operation per 3 cycles; the next accept can occur in the cycle after DONE.
REQ-015 Arithmetic is modulo 2^N; the block performs no arithmetic itself, only selection and capture.

Reset
REQ-017 While rst_n=0:
- acc=0, all flags=0, alu_a=0, alu_b=0, alu_select=0000, done=0, state=IDLE.
- op_ready=1, so a request can be accepted on the first clock edge after release.
REQ-018 Reset during EXEC or DONE aborts the operation: no done pulse, no acc or flag update.

Configuration
REQ-016 Macro ALU_CTRL_ILLEGAL_EN:
- Defined: op_illegal exists and pulses together with done for undefined codes; it is 0 otherwise and 0 in reset.
- Undefined: the port is absent; undefined codes remain NOP.

Structure
REQ-019 Package alu_ctrl_pkg holds:
- opcode localparams: OP_TRA, OP_INC, OP_ADD, OP_ADC, OP_ADDN, OP_SUB, OP_DEC, OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_NOT;
- the state enum type;
- the default width constant.
REQ-020 One combinational sub-module, alu_ctrl_decode: maps op_code and flag_c to alu_select, an a-source select and a legal bit. The FSM and registers stay in alu_ctrl.

Verification (N=4; the bench connects the team ALU to the alu_* ports)
REQ-021 LOAD 0101, then ADD 0011 -> acc=1000, flag_s=1, flag_v=1, flag_c=0, flag_z=0; done exactly 2 cycles after each accept.
REQ-022 LOAD 1111, ADD 0001 -> acc=0000, flag_z=1, flag_c=1; then ADC 0000 -> alu_select=0011 observed in EXEC, acc=0001.
REQ-023 LOAD 0011, SUB (0101) 0101 -> acc=1110, flag_s=1, flag_c=0.
REQ-024 Hold op_valid high through EXEC and DONE -> op_ready=0 there, exactly one operation executed per accept.
REQ-025 Assert rst_n=0 during EXEC -> acc=0, flags=0, no done, op_ready=1 while in reset.
REQ-026 op_code 1001 after LOAD 0110 -> acc stays 0110, flags unchanged, done=1; op_illegal=1 in the same cycle only with ALU_CTRL_ILLEGAL_EN.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM state type and default data width for the ALU controller.
package alu_ctrl_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [3:0] OP_TRA  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADC  = 4'b0011;
  localparam logic [3:0] OP_ADDN = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_DEC  = 4'b0110;
  localparam logic [3:0] OP_LOAD = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOT  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decode: ALU select, operand-a source and legality.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op_code,
  input  logic       flag_c,
  output logic [3:0] alu_select,
  output logic       a_sel,
  output logic       legal
);

  always_comb begin
    alu_select = op_code;
    a_sel      = 1'b0;
    legal      = 1'b1;
    case (op_code)
      // LOAD passes the operand straight through the ALU as a transfer
      OP_LOAD: begin
        alu_select = OP_TRA;
        a_sel      = 1'b1;
      end
      OP_ADC:  alu_select = flag_c ? OP_ADC : OP_ADD;
      OP_TRA, OP_INC, OP_ADD, OP_ADDN, OP_SUB, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Accumulator/flag controller sequencing an external ALU (IDLE -> EXEC -> DONE).
// Optional ALU_CTRL_ILLEGAL_EN adds an op_illegal pulse for undefined opcodes.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned N = ALU_CTRL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  input  logic [3:0]   op_code,
  input  logic [N-1:0] op_operand,
  output logic         op_ready,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_s,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic [N-1:0] acc,
  output logic         flag_z,
  output logic         flag_s,
  output logic         flag_v,
  output logic         flag_c,
  output logic         done
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic         op_illegal
`endif
);

  state_t     state;
  logic [3:0] dec_select;
  logic       dec_a_sel;
  logic       dec_legal;
  logic       legal_q;

  alu_ctrl_decode u_decode (
    .op_code    (op_code),
    .flag_c     (flag_c),
    .alu_select (dec_select),
    .a_sel      (dec_a_sel),
    .legal      (dec_legal)
  );

  assign op_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      legal_q    <= 1'b0;
      acc        <= '0;
      flag_z     <= 1'b0;
      flag_s     <= 1'b0;
      flag_v     <= 1'b0;
      flag_c     <= 1'b0;
      done       <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
      op_illegal <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
      op_illegal <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // ALU inputs are registered here so they hold steady through EXEC
          if (op_valid) begin
            state      <= ST_EXEC;
            alu_a      <= dec_a_sel ? op_operand : acc;
            alu_b      <= op_operand;
            alu_select <= dec_select;
            legal_q    <= dec_legal;
          end
        end
        ST_EXEC: begin
          state <= ST_DONE;
          done  <= 1'b1;
`ifdef ALU_CTRL_ILLEGAL_EN
          op_illegal <= ~legal_q;
`endif
          if (legal_q) begin
            acc    <= alu_result;
            flag_z <= alu_z;
            flag_s <= alu_s;
            flag_v <= alu_v;
            flag_c <= alu_c;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural ALU and an accumulator reference model.
module tb_alu_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [3:0]   op_code = '0;
  logic [W-1:0] op_operand = '0;
  logic         op_ready;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_select;
  logic         alu_z, alu_s, alu_v, alu_c;
  logic [W-1:0] acc;
  logic         flag_z, flag_s, flag_v, flag_c, done;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic         op_illegal;
`endif

  int tests = 0;
  int fails = 0;

  logic [3:0] m_acc;
  bit         m_z, m_s, m_v, m_c;

  alu_ctrl #(.N(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_operand (op_operand),
    .op_ready   (op_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_s      (alu_s),
    .alu_v      (alu_v),
    .alu_c      (alu_c),
    .acc        (acc),
    .flag_z     (flag_z),
    .flag_s     (flag_s),
    .flag_v     (flag_v),
    .flag_c     (flag_c),
    .done       (done)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .op_illegal (op_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Team ALU behaviour: bit-level adder with carry-in, logic ops, z/s from result.
  always_comb begin
    logic [3:0] bb;
    logic [4:0] sum;
    bb         = alu_b;
    sum        = '0;
    alu_result = '0;
    alu_v      = 1'b0;
    alu_c      = 1'b0;
    case (alu_select)
      4'b0000: alu_result = alu_a;
      4'b0001: begin sum = {1'b0, alu_a} + 5'd1; alu_v = ~alu_a[3] & sum[3]; end
      4'b0010: sum = {1'b0, alu_a} + {1'b0, bb};
      4'b0011: sum = {1'b0, alu_a} + {1'b0, bb} + 5'd1;
      4'b0100: begin bb = ~alu_b; sum = {1'b0, alu_a} + {1'b0, bb}; end
      4'b0101: begin bb = ~alu_b; sum = {1'b0, alu_a} + {1'b0, bb} + 5'd1; end
      4'b0110: begin sum = {1'b0, alu_a} + 5'h0F; alu_v = alu_a[3] & ~sum[3]; end
      4'b1000: alu_result = alu_a & alu_b;
      4'b1010: alu_result = alu_a | alu_b;
      4'b1100: alu_result = alu_a ^ alu_b;
      4'b1110: alu_result = ~alu_a;
      default: begin alu_result = 4'hA; alu_v = 1'b1; alu_c = 1'b1; end
    endcase
    if (alu_select inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110}) begin
      alu_result = sum[3:0];
      alu_c      = sum[4];
      if (alu_select inside {4'b0010, 4'b0011, 4'b0100, 4'b0101})
        alu_v = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);
    end
    alu_z = (alu_result == 4'h0);
    alu_s = alu_result[3];
    if (!(alu_select inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                             4'b0110, 4'b1000, 4'b1010, 4'b1100, 4'b1110})) begin
      alu_z = 1'b1;
      alu_s = 1'b1;
    end
  end

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference: accumulator semantics in plain integer arithmetic.
  task automatic model_apply(input logic [3:0] code, input logic [3:0] opd);
    int a, b, r, sv;
    bit cc, upd;
    a = int'(m_acc); b = int'(opd); r = 0; sv = 0; cc = 0; upd = 1;
    case (code)
      4'b0000: begin r = a; sv = 0; end
      4'b0001: begin r = a + 1; cc = (a + 1) > 15; sv = sgn(a) + 1; end
      4'b0010: begin r = a + b; cc = r > 15; sv = sgn(a) + sgn(b); end
      4'b0011: begin
        r = a + b + (m_c ? 1 : 0); cc = r > 15; sv = sgn(a) + sgn(b) + (m_c ? 1 : 0);
      end
      4'b0100: begin r = a + (15 - b); cc = r > 15; sv = sgn(a) + sgn(15 - b); end
      4'b0101: begin r = a - b; cc = a >= b; sv = sgn(a) - sgn(b); end
      4'b0110: begin r = a - 1; cc = a >= 1; sv = sgn(a) - 1; end
      4'b0111: r = b;
      4'b1000: r = a & b;
      4'b1010: r = a | b;
      4'b1100: r = a ^ b;
      4'b1110: r = 15 - a;
      default: upd = 0;
    endcase
    if (upd) begin
      r     = ((r % 16) + 16) % 16;
      m_acc = 4'(r);
      m_z   = (r == 0);
      m_s   = (r >= 8);
      m_v   = (sv > 7) || (sv < -8);
      m_c   = cc;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_acc"}, 32'(acc), 32'(m_acc));
    check({tag, "_z"}, 32'(flag_z), 32'(m_z));
    check({tag, "_s"}, 32'(flag_s), 32'(m_s));
    check({tag, "_v"}, 32'(flag_v), 32'(m_v));
    check({tag, "_c"}, 32'(flag_c), 32'(m_c));
  endtask

  // One operation starting at a negedge; ends on the negedge after DONE.
  task automatic do_op(input logic [3:0] code, input logic [3:0] opd, input bit hold);
    int n;
    logic [3:0] exp_a, exp_sel;
    logic [3:0] acc_after;
    n = 0;
    while (!op_ready && n < 10) begin @(negedge clk); n++; end
    check("ready_wait", 32'(op_ready), 32'd1);
    exp_a   = (code == 4'b0111) ? opd : m_acc;
    exp_sel = (code == 4'b0111) ? 4'b0000 :
              (code == 4'b0011) ? (m_c ? 4'b0011 : 4'b0010) : code;
    op_valid = 1'b1; op_code = code; op_operand = opd;
    @(posedge clk); #1;
    if (!hold) begin
      op_valid = 1'b0; op_code = 4'($urandom); op_operand = 4'($urandom);
    end
    @(negedge clk);
    check("exec_done", 32'(done), 32'd0);
    check("exec_ready", 32'(op_ready), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'(exp_a));
    check("exec_alu_b", 32'(alu_b), 32'(opd));
    check("exec_alu_sel", 32'(alu_select), 32'(exp_sel));
    @(negedge clk);
    model_apply(code, opd);
    check("done_pulse", 32'(done), 32'd1);
    check("done_ready", 32'(op_ready), 32'd0);
    check_state("done");
`ifdef ALU_CTRL_ILLEGAL_EN
    check("done_illegal", 32'(op_illegal),
          32'(!(code inside {[4'b0000:4'b1000], 4'b1010, 4'b1100, 4'b1110})));
`endif
    op_valid = 1'b0;
    acc_after = m_acc;
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_ready", 32'(op_ready), 32'd1);
    check("post_acc", 32'(acc), 32'(acc_after));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_acc = '0; m_z = 0; m_s = 0; m_v = 0; m_c = 0;
    @(negedge clk);
    check_state("reset");
    check("reset_ready", 32'(op_ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_alu_sel", 32'(alu_select), 32'd0);
    rst_n = 1'b1;

    // 5 + 3 overflows into the sign bit
    do_op(4'b0111, 4'h5, 0);
    do_op(4'b0010, 4'h3, 0);
    check("r21_acc", 32'(acc), 32'h8);
    check("r21_flags", 32'({flag_z, flag_s, flag_v, flag_c}), 32'b0110);

    do_op(4'b0111, 4'hF, 0);
    do_op(4'b0010, 4'h1, 0);
    check("r22_zc", 32'({flag_z, flag_c}), 32'b11);
    do_op(4'b0011, 4'h0, 0);
    check("r22_adc_acc", 32'(acc), 32'h1);

    do_op(4'b0111, 4'h3, 0);
    do_op(4'b0101, 4'h5, 0);
    check("r23_acc", 32'(acc), 32'hE);
    check("r23_sc", 32'({flag_s, flag_c}), 32'b10);

    do_op(4'b0001, 4'h7, 1);

    do_op(4'b0111, 4'h6, 0);
    do_op(4'b1001, 4'h2, 0);
    check("r26_acc", 32'(acc), 32'h6);

    // Reset asserted mid-EXEC aborts the operation
    op_valid = 1'b1; op_code = 4'b0010; op_operand = 4'h4;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_acc = '0; m_z = 0; m_s = 0; m_v = 0; m_c = 0;
    check_state("rst_exec");
    check("rst_exec_done", 32'(done), 32'd0);
    check("rst_exec_ready", 32'(op_ready), 32'd1);
    check("rst_exec_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    check("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_done", 32'(done), 32'd0);
    check_state("rst_after");

    for (int i = 0; i < 60; i++)
      do_op(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
